memory_access: RTL and testbench

Pipeline stage between execute and writeback. Latches one instruction per slot, runs at most one load or store on the data-memory bus through a two-state handshake FSM, and formats load data. Drives the writeback stage's inputs from a stage register, so writeback sees an instruction only after its bus access has completed.

---
 rtl/memory_access.sv | 163 ++++++++++++++++
 tb/tb_memory_access.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/memory_access.sv
// memory_access: pipeline stage between execute and writeback; one bus access per slot, load formatting
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   *_in                    instruction fields from execute
//   stall, invalidate       hazard controls
//   mem_*                   data-memory bus (request outputs, mem_ready/mem_load_data inputs)
//   *_out                   instruction fields to writeback, load_data_out is the formatted load result
//   busy                    stage is holding a bus access
// Build option: define MEMORY_MISALIGN_EXC_EN to raise misaligned-access exceptions
// instead of masking the low address bits.
module memory_access (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_in,
    input  logic [31:0] next_pc_in,
    input  logic [31:0] alu_data_in,
    input  logic [31:0] csr_data_in,
    input  logic [31:0] store_data_in,
    input  logic [1:0]  write_select_in,
    input  logic [4:0]  rd_address_in,
    input  logic [11:0] csr_address_in,
    input  logic        csr_write_in,
    input  logic        mret_in,
    input  logic        wfi_in,
    input  logic        load_in,
    input  logic        store_in,
    input  logic [1:0]  size_in,
    input  logic        signed_in,
    input  logic        valid_in,
    input  logic        exception_in,
    input  logic [3:0]  ecause_in,
    input  logic        stall,
    input  logic        invalidate,
    output logic [31:0] mem_address,
    output logic [31:0] mem_store_data,
    output logic [3:0]  mem_byte_enable,
    output logic        mem_read,
    output logic        mem_write,
    input  logic        mem_ready,
    input  logic [31:0] mem_load_data,
    output logic [31:0] pc_out,
    output logic [31:0] next_pc_out,
    output logic [31:0] alu_data_out,
    output logic [31:0] csr_data_out,
    output logic [31:0] load_data_out,
    output logic [1:0]  write_select_out,
    output logic [4:0]  rd_address_out,
    output logic [11:0] csr_address_out,
    output logic        csr_write_out,
    output logic        mret_out,
    output logic        wfi_out,
    output logic        valid_out,
    output logic        exception_out,
    output logic [3:0]  ecause_out,
    output logic        busy
);
`ifdef MEMORY_MISALIGN_EXC_EN
    localparam logic MIS_EN = 1'b1;
`else
    localparam logic MIS_EN = 1'b0;
`endif

    typedef enum logic {IDLE, ACCESS} state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] next_pc;
        logic [31:0] alu_data;
        logic [31:0] csr_data;
        logic [31:0] store_data;
        logic [1:0]  write_select;
        logic [4:0]  rd_address;
        logic [11:0] csr_address;
        logic        csr_write;
        logic        mret;
        logic        wfi;
        logic        load;
        logic        store;
        logic [1:0]  size;
        logic        sign;
        logic        valid;
        logic        exception;
        logic [3:0]  ecause;
    } stage_t;

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr);
        return MIS_EN && ((size == 2'b01 && addr[0]) || (size == 2'b10 && addr != 2'b00));
    endfunction

    state_t      state_q, state_d;
    stage_t      r_q, r_d, in_s;
    logic [31:0] load_q, load_d;
    logic [31:0] addr, sh, fmt;
    logic [3:0]  be;
    logic        access, start, mis_r;

    assign in_s = '{pc: pc_in, next_pc: next_pc_in, alu_data: alu_data_in, csr_data: csr_data_in,
                    store_data: store_data_in, write_select: write_select_in, rd_address: rd_address_in,
                    csr_address: csr_address_in, csr_write: csr_write_in, mret: mret_in, wfi: wfi_in,
                    load: load_in, store: store_in, size: size_in, sign: signed_in, valid: valid_in,
                    exception: exception_in, ecause: ecause_in};

    assign access = (state_q == ACCESS);
    assign busy   = access;
    assign start  = !busy && !stall && valid_in && !invalidate && !exception_in &&
                    (load_in || store_in) && !misaligned(size_in, alu_data_in[1:0]);
    assign mis_r  = (r_q.load || r_q.store) && misaligned(r_q.size, r_q.alu_data[1:0]);

    // Low bits are always masked by size; with misalign exceptions enabled an access
    // only starts when those bits are already zero, so the mask is harmless there.
    assign addr = {r_q.alu_data[31:2], r_q.alu_data[1] & (r_q.size[1] == 1'b0),
                   r_q.alu_data[0] & (r_q.size == 2'b00)};
    assign be   = r_q.size == 2'b00 ? 4'b0001 << addr[1:0] :
                  r_q.size == 2'b01 ? 4'b0011 << addr[1:0] : 4'b1111;
    assign sh   = mem_load_data >> {addr[1:0], 3'b000};
    assign fmt  = r_q.size == 2'b00 ? {{24{r_q.sign & sh[7]}}, sh[7:0]} :
                  r_q.size == 2'b01 ? {{16{r_q.sign & sh[15]}}, sh[15:0]} : sh;

    always_comb begin
        r_d       = (!busy && !stall) ? in_s : r_q;
        r_d.valid = r_d.valid && !invalidate;
    end

    always_comb begin
        state_d = access ? ((mem_ready || invalidate) ? IDLE : ACCESS) : (start ? ACCESS : IDLE);
        load_d  = (mem_read && mem_ready) ? fmt : load_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            r_q     <= '0;
            load_q  <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            load_q  <= load_d;
        end
    end

    assign mem_read        = access && r_q.load;
    assign mem_write       = access && r_q.store && !invalidate;
    assign mem_address     = access ? addr : 32'd0;
    assign mem_byte_enable = access ? be : 4'd0;
    assign mem_store_data  = !access ? 32'd0 :
                             r_q.size == 2'b00 ? {4{r_q.store_data[7:0]}} :
                             r_q.size == 2'b01 ? {2{r_q.store_data[15:0]}} : r_q.store_data;

    assign pc_out           = r_q.pc;
    assign next_pc_out      = r_q.next_pc;
    assign alu_data_out     = r_q.alu_data;
    assign csr_data_out     = r_q.csr_data;
    assign load_data_out    = load_q;
    assign write_select_out = r_q.write_select;
    assign rd_address_out   = r_q.rd_address;
    assign csr_address_out  = r_q.csr_address;
    assign csr_write_out    = r_q.csr_write;
    assign mret_out         = r_q.mret;
    assign wfi_out          = r_q.wfi;
    assign valid_out        = r_q.valid && !access;
    assign exception_out    = r_q.exception || mis_r;
    assign ecause_out       = r_q.exception ? r_q.ecause : mis_r ? (r_q.load ? 4'd4 : 4'd6) : 4'd0;
endmodule

// File: tb/tb_memory_access.sv
// tb_memory_access: randomized self-checking bench for memory_access against a behavioural model
module tb_memory_access;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_in, next_pc_in, alu_data_in, csr_data_in, store_data_in;
    logic [1:0]  write_select_in, size_in;
    logic [4:0]  rd_address_in;
    logic [11:0] csr_address_in;
    logic        csr_write_in, mret_in, wfi_in, load_in, store_in, signed_in;
    logic        valid_in, exception_in, stall, invalidate;
    logic [3:0]  ecause_in;
    logic [31:0] mem_address, mem_store_data, mem_load_data;
    logic [3:0]  mem_byte_enable;
    logic        mem_read, mem_write, mem_ready;
    logic [31:0] pc_out, next_pc_out, alu_data_out, csr_data_out, load_data_out;
    logic [1:0]  write_select_out;
    logic [4:0]  rd_address_out;
    logic [11:0] csr_address_out;
    logic        csr_write_out, mret_out, wfi_out, valid_out, exception_out, busy;
    logic [3:0]  ecause_out;

    int          total = 0;
    int          bad = 0;
    logic [31:0] last_ld = 32'd0;

    always #5 clk = ~clk;

    memory_access dut (
        .clk(clk), .reset(reset),
        .pc_in(pc_in), .next_pc_in(next_pc_in), .alu_data_in(alu_data_in), .csr_data_in(csr_data_in),
        .store_data_in(store_data_in), .write_select_in(write_select_in), .rd_address_in(rd_address_in),
        .csr_address_in(csr_address_in), .csr_write_in(csr_write_in), .mret_in(mret_in), .wfi_in(wfi_in),
        .load_in(load_in), .store_in(store_in), .size_in(size_in), .signed_in(signed_in),
        .valid_in(valid_in), .exception_in(exception_in), .ecause_in(ecause_in),
        .stall(stall), .invalidate(invalidate),
        .mem_address(mem_address), .mem_store_data(mem_store_data), .mem_byte_enable(mem_byte_enable),
        .mem_read(mem_read), .mem_write(mem_write), .mem_ready(mem_ready), .mem_load_data(mem_load_data),
        .pc_out(pc_out), .next_pc_out(next_pc_out), .alu_data_out(alu_data_out), .csr_data_out(csr_data_out),
        .load_data_out(load_data_out), .write_select_out(write_select_out), .rd_address_out(rd_address_out),
        .csr_address_out(csr_address_out), .csr_write_out(csr_write_out), .mret_out(mret_out),
        .wfi_out(wfi_out), .valid_out(valid_out), .exception_out(exception_out), .ecause_out(ecause_out),
        .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic ld, input logic st, input logic [1:0] sz, input logic sg,
                         input logic [31:0] addr, input logic [31:0] sdata, input logic [31:0] pc,
                         input logic exc, input logic [3:0] ec);
        pc_in = pc; next_pc_in = pc + 4; alu_data_in = addr; csr_data_in = $urandom;
        store_data_in = sdata; write_select_in = 2'($urandom); rd_address_in = 5'($urandom);
        csr_address_in = 12'($urandom); csr_write_in = 1'($urandom); mret_in = 1'($urandom);
        wfi_in = 1'($urandom); load_in = ld; store_in = st; size_in = sz; signed_in = sg;
        valid_in = 1'b1; exception_in = exc; ecause_in = ec;
    endtask

    task automatic quiet();
        valid_in = 1'b0; load_in = 1'b0; store_in = 1'b0; exception_in = 1'b0; ecause_in = 4'd0;
    endtask

    task automatic run_op(input logic ld, input logic st, input logic [1:0] sz, input logic sg,
                          input logic [31:0] addr, input logic [31:0] sdata, input logic [31:0] ldata,
                          input int wn, input logic exc, input logic [3:0] ec);
        logic [31:0] a, sh, exp_ld, sd, pc;
        logic [3:0]  be, cause;
        logic        mis, mem;
        pc = $urandom;
        a = addr;
        if (sz == 2'd1) a[0] = 1'b0;
        else if (sz == 2'd2) a[1:0] = 2'b00;
        mis = 1'b0;
`ifdef MEMORY_MISALIGN_EXC_EN
        mis = (ld || st) && (a != addr);
`endif
        mem = (ld || st) && !exc && !mis;
        be = sz == 2'd0 ? 4'b0001 << a[1:0] : sz == 2'd1 ? 4'b0011 << a[1:0] : 4'b1111;
        sd = sz == 2'd0 ? {4{sdata[7:0]}} : sz == 2'd1 ? {2{sdata[15:0]}} : sdata;
        sh = ldata >> (8 * a[1:0]);
        exp_ld = sz == 2'd0 ? (sh & 32'd255) : sz == 2'd1 ? (sh & 32'd65535) : ldata;
        if (sg && sz == 2'd0 && exp_ld >= 32'd128) exp_ld = exp_ld - 32'd256;
        if (sg && sz == 2'd1 && exp_ld >= 32'd32768) exp_ld = exp_ld - 32'd65536;
        cause = exc ? ec : mis ? (ld ? 4'd4 : 4'd6) : 4'd0;
        drive(ld, st, sz, sg, addr, sdata, pc, exc, ec);
        @(negedge clk);
        quiet();
        if (mem) begin
            chk("busy", busy, 1);
            chk("vout_busy", valid_out, 0);
            chk("mem_read", mem_read, ld);
            chk("mem_write", mem_write, st);
            chk("mem_addr", mem_address, a);
            chk("byte_en", mem_byte_enable, be);
            if (st) chk("store_data", mem_store_data, sd);
            repeat (wn) begin
                @(negedge clk);
                chk("busy_wait", busy, 1);
            end
            mem_ready = 1'b1; mem_load_data = ldata;
            @(negedge clk);
            mem_ready = 1'b0; mem_load_data = $urandom;
            if (ld) last_ld = exp_ld;
        end else begin
            chk("mem_read_idle", mem_read, 0);
            chk("mem_write_idle", mem_write, 0);
            mem_ready = 1'b1; mem_load_data = $urandom;
        end
        chk("busy_done", busy, 0);
        chk("vout", valid_out, 1);
        chk("pc_out", pc_out, pc);
        chk("next_pc_out", next_pc_out, pc + 4);
        chk("exception", exception_out, exc || mis);
        chk("ecause", ecause_out, cause);
        chk("load_data", load_data_out, last_ld);
        @(negedge clk);
        mem_ready = 1'b0;
        chk("vout_bubble", valid_out, 0);
        chk("load_data_hold", load_data_out, last_ld);
    endtask

    initial begin
        logic [31:0] p1, p2, x;
        int k;
        reset = 1'b1; stall = 1'b0; invalidate = 1'b0; mem_ready = 1'b0; mem_load_data = 32'd0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        quiet();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_vout", valid_out, 0);
        chk("rst_pc", pc_out, 0);
        chk("rst_ld", load_data_out, 0);
        chk("rst_mrd", mem_read, 0);
        chk("rst_be", mem_byte_enable, 0);

        run_op(1, 0, 2'd2, 0, 32'h100, 0, 32'hDEADBEEF, 2, 0, 0);
        run_op(1, 0, 2'd0, 1, 32'h103, 0, 32'h80FFFFFF, 0, 0, 0);
        run_op(1, 0, 2'd0, 0, 32'h103, 0, 32'h80FFFFFF, 1, 0, 0);
        run_op(0, 1, 2'd1, 0, 32'h202, 32'h1234ABCD, 0, 0, 0, 0);
        run_op(1, 0, 2'd2, 0, 32'h101, 0, 32'h11223344, 0, 0, 0);
        run_op(0, 1, 2'd2, 0, 32'h302, 32'h55667788, 0, 0, 0, 0);
        run_op(1, 0, 2'd1, 1, 32'h402, 0, 32'h9ABC0000, 0, 0, 0);
        run_op(1, 0, 2'd2, 0, 32'h500, 0, 32'h1, 0, 1, 4'd2);

        drive(0, 1, 2'd2, 0, 32'h300, 32'hCAFEF00D, 32'h40, 0, 0);
        @(negedge clk);
        quiet();
        chk("inv_mwr_pre", mem_write, 1);
        invalidate = 1'b1;
        #1;
        chk("inv_mwr", mem_write, 0);
        chk("inv_busy", busy, 1);
        @(negedge clk);
        invalidate = 1'b0;
        chk("inv_busy_after", busy, 0);
        chk("inv_vout", valid_out, 0);
        @(negedge clk);
        chk("inv_vout2", valid_out, 0);

        x = $urandom;
        drive(1, 0, 2'd2, 0, 32'h400, 0, 32'h44, 0, 0);
        @(negedge clk);
        quiet();
        invalidate = 1'b1; mem_ready = 1'b1; mem_load_data = x;
        @(negedge clk);
        invalidate = 1'b0; mem_ready = 1'b0;
        last_ld = x;
        chk("invrdy_busy", busy, 0);
        chk("invrdy_vout", valid_out, 0);
        chk("invrdy_ld", load_data_out, x);
        @(negedge clk);

        p1 = $urandom; p2 = $urandom;
        drive(0, 0, 2'd2, 0, 32'h0, 0, p1, 0, 0);
        @(negedge clk);
        drive(0, 0, 2'd2, 0, 32'h0, 0, p2, 0, 0);
        stall = 1'b1;
        chk("stall_vout0", valid_out, 1);
        chk("stall_pc0", pc_out, p1);
        repeat (2) begin
            @(negedge clk);
            chk("stall_vout", valid_out, 1);
            chk("stall_pc", pc_out, p1);
        end
        stall = 1'b0;
        @(negedge clk);
        quiet();
        chk("unstall_pc", pc_out, p2);
        chk("unstall_vout", valid_out, 1);
        @(negedge clk);

        drive(1, 0, 2'd2, 0, 32'h600, 0, 32'h66, 0, 0);
        @(negedge clk);
        quiet();
        reset = 1'b1;
        #1;
        chk("rstacc_mrd_pre", mem_read, 1);
        @(negedge clk);
        reset = 1'b0;
        last_ld = 32'd0;
        chk("rstacc_mrd", mem_read, 0);
        chk("rstacc_busy", busy, 0);

        for (int i = 0; i < 40; i++) begin
            k = $urandom_range(0, 2);
            x = (k != 0 && $urandom_range(0, 7) == 0) ? 32'd1 : 32'd0;
            run_op(k == 1, k == 2, 2'($urandom_range(0, 2)), 1'($urandom), $urandom, $urandom, $urandom,
                   $urandom_range(0, 3), x[0], x[0] ? 4'($urandom) : 4'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
